irq_controller: RTL and testbench

Parametrised interrupt controller between external event sources (key, Ethernet, accelerator, further peripherals) and the pipelined RV32 core. It synchronises N asynchronous request lines and latches them as pending in edge or level mode. It arbitrates by fixed or round-robin priority and presents one interrupt at a time to fetch. It holds each request's source data for `rdi`, replacing the core's single key/eth latch with a masked, multi-source, acknowledged request/service protocol.

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_controller_if.sv | 39 +++
 rtl/irq_sync.sv | 35 +++
 rtl/irq_controller.sv | 166 ++++++++++++++++
 tb/tb_irq_controller.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types for the interrupt controller; also imported by the core top
// so it can decode the controller's debug state.
package irq_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_t;

    // Width of an id able to name n sources; never narrower than one bit.
    function automatic int IRQ_ID_W(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Request/service link between the interrupt controller and the fetch stage.
//
// Handshake: the controller raises interrupt with a stable irq_id and keeps
// both unchanged until fetch answers with a one-cycle ack; the ack edge is the
// transfer point (interrupt drops, rdi_data becomes valid for the handler).
// The handler ends with a one-cycle rti. ack while no request is presented,
// and rti while nothing is in service, are ignored by the controller.
interface irq_controller_if
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32
);
    localparam int ID_W = IRQ_ID_W(NUM_SRC);

    logic              interrupt;
    logic [ID_W-1:0]   irq_id;
    logic [DATA_W-1:0] rdi_data;
    logic              ack;
    logic              rti;

    // Controller side.
    modport master (
        output interrupt,
        output irq_id,
        output rdi_data,
        input  ack,
        input  rti
    );

    // Fetch/core side.
    modport slave (
        input  interrupt,
        input  irq_id,
        input  rdi_data,
        output ack,
        output rti
    );
endinterface

// File: rtl/irq_sync.sv
// One request line: multi-flop synchroniser plus a rise detector built on a
// delayed copy of the synced level.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);
    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;

    // Shift the raw line through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    // Remember last cycle's synced level for the rise detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= r_chain[SYNC_STAGES-1];
        end
    end

    assign o_level = r_chain[SYNC_STAGES-1];
    assign o_rise  = r_chain[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: per-source pending/overrun/hold latching, fixed or
// round-robin arbitration and the IDLE/REQ/SERVICE request FSM toward fetch.
module irq_controller
    import irq_pkg::*;
#(
    parameter int               NUM_SRC     = 4,
    parameter int               DATA_W      = 32,
    parameter int               SYNC_STAGES = 2,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = NUM_SRC'(4'b0011),
    parameter int               RR_EN       = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        irq_src,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        irq_mask,
    irq_controller_if.master          bus,
    output logic [NUM_SRC-1:0]        pending,
    output logic [NUM_SRC-1:0]        overrun,
    output irq_state_t                dbg_state
);
    localparam int ID_W = IRQ_ID_W(NUM_SRC);

    logic [NUM_SRC-1:0] w_level;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_req;
    logic [ID_W-1:0]    w_start;
    logic [ID_W-1:0]    w_winner;
    logic               w_found;

    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_overrun;
    logic [DATA_W-1:0]  r_hold [NUM_SRC];
    irq_state_t         r_state;
    logic               r_interrupt;
    logic [ID_W-1:0]    r_irq_id;
    logic [DATA_W-1:0]  r_rdi_data;
    logic [ID_W-1:0]    r_rr_ptr;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .rst     (rst),
            .i_async (irq_src[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g])
        );
    end

    // Source being acknowledged this cycle (only meaningful in REQ).
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_clr[i] = (r_state == IRQ_REQ) && bus.ack && (r_irq_id == ID_W'(i));
        end
    end

    // Latch pending/overrun and capture source data when a request appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_overrun <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (EDGE_MASK[i]) begin
                    if (w_rise[i]) begin
                        if (r_pending[i] && !w_clr[i]) begin
                            // Second event before service: flag it, keep first data.
                            r_overrun[i] <= 1'b1;
                        end else begin
                            // Fresh event, or event racing its own ack: set wins.
                            r_pending[i] <= 1'b1;
                            r_hold[i]    <= src_data[i*DATA_W +: DATA_W];
                            if (w_clr[i]) begin
                                r_overrun[i] <= 1'b0;
                            end
                        end
                    end else if (w_clr[i]) begin
                        r_pending[i] <= 1'b0;
                        r_overrun[i] <= 1'b0;
                    end
                end else begin
                    // Level source tracks the line; the ack clears it for one
                    // cycle unless a new rise lands on the same edge.
                    r_pending[i] <= w_level[i] & ~(w_clr[i] & ~w_rise[i]);
                    r_overrun[i] <= 1'b0;
                    if (w_level[i] && (w_rise[i] || !w_clr[i]) &&
                        (!r_pending[i] || w_clr[i])) begin
                        r_hold[i] <= src_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    assign w_req   = r_pending & ~irq_mask;
    assign w_start = (RR_EN != 0) ? r_rr_ptr : '0;

    // Pick the first requesting source, searching upward from w_start with wrap.
    always_comb begin
        int v_idx;
        w_found  = 1'b0;
        w_winner = '0;
        v_idx    = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            v_idx = (int'(w_start) + k) % NUM_SRC;
            if (!w_found && w_req[v_idx]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(v_idx);
            end
        end
    end

    // Request FSM with registered interrupt, id, handler data and RR pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IRQ_IDLE;
            r_interrupt <= 1'b0;
            r_irq_id    <= '0;
            r_rdi_data  <= '0;
            r_rr_ptr    <= '0;
        end else begin
            case (r_state)
                IRQ_IDLE: begin
                    if (w_found) begin
                        r_state     <= IRQ_REQ;
                        r_interrupt <= 1'b1;
                        r_irq_id    <= w_winner;
                    end
                end
                IRQ_REQ: begin
                    // Held until ack even if the winner gets masked meanwhile.
                    if (bus.ack) begin
                        r_state     <= IRQ_SERVICE;
                        r_interrupt <= 1'b0;
                        r_rdi_data  <= r_hold[r_irq_id];
                        if (RR_EN != 0) begin
                            r_rr_ptr <= (r_irq_id == ID_W'(NUM_SRC - 1)) ? '0
                                                                          : r_irq_id + 1'b1;
                        end
                    end
                end
                IRQ_SERVICE: begin
                    if (bus.rti) begin
                        r_state <= IRQ_IDLE;
                    end
                end
                default: begin
                    r_state     <= IRQ_IDLE;
                    r_interrupt <= 1'b0;
                end
            endcase
        end
    end

    assign bus.interrupt = r_interrupt;
    assign bus.irq_id    = r_irq_id;
    assign bus.rdi_data  = r_rdi_data;
    assign pending       = r_pending;
    assign overrun       = r_overrun;
    assign dbg_state     = r_state;
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a default fixed-priority instance and an
// all-edge round-robin instance, checked step by step against hand values.
module tb_irq_controller;
    import irq_pkg::*;

    logic         clk;
    logic         rst;
    logic [3:0]   irq_src;
    logic [127:0] src_data;
    logic [3:0]   irq_mask;
    logic [3:0]   pending;
    logic [3:0]   overrun;
    irq_state_t   dbg_state;

    logic [3:0]   rr_src;
    logic [127:0] rr_data;
    logic [3:0]   rr_mask;
    logic [3:0]   rr_pending;
    logic [3:0]   rr_overrun;
    irq_state_t   rr_state;

    int checks;
    int errors;

    irq_controller_if #(.NUM_SRC(4), .DATA_W(32)) bus ();
    irq_controller_if #(.NUM_SRC(4), .DATA_W(32)) rr_bus ();

    irq_controller #(.NUM_SRC(4), .DATA_W(32), .SYNC_STAGES(2),
                     .EDGE_MASK(4'b0011), .RR_EN(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .src_data  (src_data),
        .irq_mask  (irq_mask),
        .bus       (bus),
        .pending   (pending),
        .overrun   (overrun),
        .dbg_state (dbg_state)
    );

    irq_controller #(.NUM_SRC(4), .DATA_W(32), .SYNC_STAGES(2),
                     .EDGE_MASK(4'b1111), .RR_EN(1)) dut_rr (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (rr_src),
        .src_data  (rr_data),
        .irq_mask  (rr_mask),
        .bus       (rr_bus),
        .pending   (rr_pending),
        .overrun   (rr_overrun),
        .dbg_state (rr_state)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges, landing on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ack_main();
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
    endtask

    task automatic rti_main();
        bus.rti = 1'b1;
        step(1);
        bus.rti = 1'b0;
    endtask

    task automatic ack_rr();
        rr_bus.ack = 1'b1;
        step(1);
        rr_bus.ack = 1'b0;
    endtask

    task automatic rti_rr();
        rr_bus.rti = 1'b1;
        step(1);
        rr_bus.rti = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        irq_src    = '0;
        src_data   = '0;
        irq_mask   = '0;
        rr_src     = '0;
        rr_data    = '0;
        rr_mask    = '0;
        bus.ack    = 1'b0;
        bus.rti    = 1'b0;
        rr_bus.ack = 1'b0;
        rr_bus.rti = 1'b0;

        // ---- reset state ----
        step(2);
        chk("rst_interrupt", 64'(bus.interrupt), 64'(1'b0));
        chk("rst_irq_id",    64'(bus.irq_id),    64'(2'd0));
        chk("rst_rdi",       64'(bus.rdi_data),  64'(32'h0));
        chk("rst_pending",   64'(pending),       64'(4'h0));
        chk("rst_overrun",   64'(overrun),       64'(4'h0));
        chk("rst_state",     64'(dbg_state),     64'(IRQ_IDLE));
        rst = 1'b0;
        step(1);

        // ---- single edge source 1, latency and data ----
        src_data[1*32 +: 32] = 32'hDEADBEEF;
        irq_src[1] = 1'b1;
        step(2);
        chk("t1_pend_k1", 64'(pending), 64'(4'h0));
        step(1);
        chk("t1_pend_k2", 64'(pending), 64'(4'b0010));
        chk("t1_int_k2",  64'(bus.interrupt), 64'(1'b0));
        step(1);
        chk("t1_int_k3",  64'(bus.interrupt), 64'(1'b1));
        chk("t1_id",      64'(bus.irq_id), 64'(2'd1));
        irq_src[1] = 1'b0;
        ack_main();
        chk("t1_ack_int",   64'(bus.interrupt), 64'(1'b0));
        chk("t1_ack_state", 64'(dbg_state), 64'(IRQ_SERVICE));
        chk("t1_rdi",       64'(bus.rdi_data), 64'(32'hDEADBEEF));
        chk("t1_ack_id",    64'(bus.irq_id), 64'(2'd1));
        chk("t1_ack_pend",  64'(pending), 64'(4'h0));
        rti_main();
        chk("t1_rti_state", 64'(dbg_state), 64'(IRQ_IDLE));
        step(2);

        // ---- sources 0 (edge) and 2 (level) together, fixed priority ----
        src_data[0*32 +: 32] = 32'h10000000;
        src_data[2*32 +: 32] = 32'h20000002;
        irq_src[0] = 1'b1;
        irq_src[2] = 1'b1;
        step(3);
        chk("t2_pend", 64'(pending), 64'(4'b0101));
        step(1);
        chk("t2_int0", 64'(bus.interrupt), 64'(1'b1));
        chk("t2_id0",  64'(bus.irq_id), 64'(2'd0));
        irq_src[0] = 1'b0;
        ack_main();
        chk("t2_rdi0",  64'(bus.rdi_data), 64'(32'h10000000));
        chk("t2_pend2", 64'(pending), 64'(4'b0100));
        rti_main();
        chk("t2_rti_state", 64'(dbg_state), 64'(IRQ_IDLE));
        chk("t2_gap_int",   64'(bus.interrupt), 64'(1'b0));
        step(1);
        chk("t2_int2", 64'(bus.interrupt), 64'(1'b1));
        chk("t2_id2",  64'(bus.irq_id), 64'(2'd2));
        ack_main();
        chk("t2_rdi2", 64'(bus.rdi_data), 64'(32'h20000002));
        irq_src[2] = 1'b0;
        step(4);
        rti_main();
        step(1);
        chk("t2_drain_int",  64'(bus.interrupt), 64'(1'b0));
        chk("t2_drain_pend", 64'(pending), 64'(4'h0));
        chk("t2_overrun",    64'(overrun), 64'(4'h0));

        // ---- source 1 pulses twice before ack: overrun ----
        src_data[1*32 +: 32] = 32'h11111111;
        irq_src[1] = 1'b1;
        step(2);
        irq_src[1] = 1'b0;
        step(1);
        src_data[1*32 +: 32] = 32'h22222222;
        step(1);
        chk("t3_int", 64'(bus.interrupt), 64'(1'b1));
        irq_src[1] = 1'b1;
        step(2);
        irq_src[1] = 1'b0;
        step(3);
        chk("t3_overrun", 64'(overrun), 64'(4'b0010));
        chk("t3_id",      64'(bus.irq_id), 64'(2'd1));
        ack_main();
        chk("t3_rdi",        64'(bus.rdi_data), 64'(32'h11111111));
        chk("t3_ovr_clear",  64'(overrun), 64'(4'h0));
        rti_main();
        step(2);

        // ---- level source 3 held through ack and rti ----
        src_data[3*32 +: 32] = 32'h33333333;
        irq_src[3] = 1'b1;
        step(4);
        chk("t4_int", 64'(bus.interrupt), 64'(1'b1));
        chk("t4_id",  64'(bus.irq_id), 64'(2'd3));
        ack_main();
        chk("t4_rdi",     64'(bus.rdi_data), 64'(32'h33333333));
        chk("t4_ack_pend", 64'(pending), 64'(4'h0));
        step(1);
        chk("t4_repend", 64'(pending), 64'(4'b1000));
        rti_main();
        step(1);
        chk("t4_reint",  64'(bus.interrupt), 64'(1'b1));
        chk("t4_reid",   64'(bus.irq_id), 64'(2'd3));
        chk("t4_ovr",    64'(overrun), 64'(4'h0));
        irq_src[3] = 1'b0;
        ack_main();
        step(4);
        rti_main();
        step(1);
        chk("t4_drain_state", 64'(dbg_state), 64'(IRQ_IDLE));
        chk("t4_drain_pend",  64'(pending), 64'(4'h0));

        // ---- masked source 0 ----
        irq_mask[0] = 1'b1;
        src_data[0*32 +: 32] = 32'h0A0A0A0A;
        irq_src[0] = 1'b1;
        step(1);
        irq_src[0] = 1'b0;
        step(4);
        chk("t5_pend",   64'(pending), 64'(4'b0001));
        chk("t5_no_int", 64'(bus.interrupt), 64'(1'b0));
        irq_mask[0] = 1'b0;
        step(2);
        chk("t5_int", 64'(bus.interrupt), 64'(1'b1));
        chk("t5_id",  64'(bus.irq_id), 64'(2'd0));
        ack_main();
        chk("t5_rdi", 64'(bus.rdi_data), 64'(32'h0A0A0A0A));
        rti_main();
        step(2);

        // ---- round-robin instance: pointer moved to 1, then 0 and 2 race ----
        rr_data[0*32 +: 32] = 32'hA0A0A0A0;
        rr_src[0] = 1'b1;
        step(1);
        rr_src[0] = 1'b0;
        step(3);
        chk("rr_first_int", 64'(rr_bus.interrupt), 64'(1'b1));
        chk("rr_first_id",  64'(rr_bus.irq_id), 64'(2'd0));
        ack_rr();
        rti_rr();
        step(1);
        rr_data[0*32 +: 32] = 32'hB0B0B0B0;
        rr_data[2*32 +: 32] = 32'hC2C2C2C2;
        rr_src[0] = 1'b1;
        rr_src[2] = 1'b1;
        step(1);
        rr_src[0] = 1'b0;
        rr_src[2] = 1'b0;
        step(3);
        chk("rr_pend", 64'(rr_pending), 64'(4'b0101));
        chk("rr_id2",  64'(rr_bus.irq_id), 64'(2'd2));
        ack_rr();
        chk("rr_rdi2", 64'(rr_bus.rdi_data), 64'(32'hC2C2C2C2));
        rti_rr();
        step(1);
        chk("rr_int0", 64'(rr_bus.interrupt), 64'(1'b1));
        chk("rr_id0",  64'(rr_bus.irq_id), 64'(2'd0));
        ack_rr();
        chk("rr_rdi0", 64'(rr_bus.rdi_data), 64'(32'hB0B0B0B0));
        rti_rr();
        step(1);

        // ---- reset during service, then stray rti/ack ----
        src_data[1*32 +: 32] = 32'h55555555;
        irq_src[1] = 1'b1;
        step(4);
        chk("t6_int", 64'(bus.interrupt), 64'(1'b1));
        irq_src[1] = 1'b0;
        ack_main();
        chk("t6_rdi",   64'(bus.rdi_data), 64'(32'h55555555));
        chk("t6_state", 64'(dbg_state), 64'(IRQ_SERVICE));
        rst = 1'b1;
        #1;
        chk("t6_rst_state", 64'(dbg_state), 64'(IRQ_IDLE));
        chk("t6_rst_rdi",   64'(bus.rdi_data), 64'(32'h0));
        chk("t6_rst_id",    64'(bus.irq_id), 64'(2'd0));
        chk("t6_rst_int",   64'(bus.interrupt), 64'(1'b0));
        chk("t6_rst_pend",  64'(pending), 64'(4'h0));
        chk("t6_rst_ovr",   64'(overrun), 64'(4'h0));
        step(1);
        rst = 1'b0;
        step(1);
        rti_main();
        ack_main();
        step(1);
        chk("t6_stray_state", 64'(dbg_state), 64'(IRQ_IDLE));
        chk("t6_stray_int",   64'(bus.interrupt), 64'(1'b0));
        chk("t6_stray_rdi",   64'(bus.rdi_data), 64'(32'h0));
        chk("t6_stray_id",    64'(bus.irq_id), 64'(2'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
